// File: rtl/div32_seq.sv
// div32_seq - multi-cycle restoring divider (one quotient bit per clock)
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   start                 request; taken only in IDLE or DONE
//   dividend, divisor     operands, latched on the accept edge
//   busy                  high while iterating (CALC)
//   done                  one-cycle pulse, results valid from this cycle on
//   quotient, remainder   registered results, held until the next completion
//   div_by_zero           registered flag, valid with done
//
// Build option
//   DIV32_SIGNED_EN  two's-complement operands (truncating division). When
//                    undefined the unit is purely unsigned and no sign
//                    logic exists.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } res_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;   // partial remainder
  res_t             res_q;

  logic             accept, last, qbit;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, q_fix, r_fix;

  assign accept = start && (state != CALC);
  assign last   = (cnt == CW'(WIDTH - 1));

`ifdef DIV32_SIGNED_EN
  logic neg_q, neg_r;

  // Divide magnitudes; -2^(W-1) maps to itself, which is its correct
  // unsigned magnitude.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  // Fix-up on the completing edge; remainder follows the dividend's sign.
  assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fix   = neg_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = quo_nxt;
  assign r_fix   = rem_nxt;
`endif

  // One restoring step. The shifted remainder can reach nearly 2^(W+1), so
  // the trial subtract carries an extra top bit that holds the borrow.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
  assign qbit    = ~diff[WIDTH+1];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt = {dvd_q[WIDTH-2:0], qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      dvd_q <= dvd_mag;
      dvs_q <= dvs_mag;
      rem_q <= '0;
      // Zero divisor skips CALC; result is written on the accept edge.
      if (divisor == '0) res_q <= '{q: '1, r: dividend, dbz: 1'b1};
    end else if (state == CALC) begin
      cnt   <= cnt + CW'(1);
      dvd_q <= quo_nxt;
      rem_q <= rem_nxt;
      if (last) res_q <= '{q: q_fix, r: r_fix, dbz: 1'b0};
    end
  end

  assign busy        = (state == CALC);
  assign done        = (state == DONE);
  assign quotient    = res_q.q;
  assign remainder   = res_q.r;
  assign div_by_zero = res_q.dbz;

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq - directed self-checking bench for div32_seq (WIDTH = 32).
// Signed vectors are compiled in only with DIV32_SIGNED_EN.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int failures = 0;

  div32_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done is seen (bounded); counts busy cycles on the way.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done && n < 200) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input int elat);
    int n, nb;
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    wait_done(n, nb);
    chk({tag, "_lat"},  n,  elat);
    chk({tag, "_busy"}, nb, elat);
    chk({tag, "_q"},    quotient,    eq);
    chk({tag, "_r"},    remainder,   er);
    chk({tag, "_dbz"},  div_by_zero, ez);
    tick();
    chk({tag, "_pulse"}, done,     1'b0);
    chk({tag, "_holdq"}, quotient, eq);
    chk({tag, "_holdz"}, div_by_zero, ez);
  endtask

  initial begin
    int n, nb, dseen;

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q",    quotient, 32'h0);
    chk("rst_r",    remainder, 32'h0);
    chk("rst_dbz",  div_by_zero, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_div("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    run_div("dbz", 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 0);
    run_div("max_by1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
`ifndef DIV32_SIGNED_EN
    run_div("small_bymax", 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, 32);
`endif

    // start during CALC is ignored; original result delivered
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    chk("hs_lat", n, 26);
    chk("hs_q", quotient, 32'd100);
    chk("hs_r", remainder, 32'd0);
    // hold start through DONE: back-to-back accept
    start = 1'b1; dividend = 32'd77; divisor = 32'd4;
    tick();
    start = 1'b0;
    wait_done(n, nb);
    chk("b2b_lat", n + 1, 33);
    chk("b2b_q", quotient, 32'd19);
    chk("b2b_r", remainder, 32'd1);
    tick();

    // reset abort at CALC cycle 10
    start = 1'b1; dividend = 32'd12345; divisor = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("abort_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", quotient, 32'h0);
    chk("abort_r", remainder, 32'h0);
    chk("abort_dbz", div_by_zero, 1'b0);
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;
    dseen = 0;
    repeat (40) begin
      tick();
      if (done || busy) dseen++;
    end
    chk("abort_nodone", dseen, 0);
    run_div("post_rst", 32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 32);

`ifdef DIV32_SIGNED_EN
    run_div("s_neg7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
    run_div("s_7_neg2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 32);
    run_div("s_min_neg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32);
    run_div("s_dbz", 32'hFFFF_FF00, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
# div32_seq

Multi-cycle restoring divider that sits beside the combinational 32-bit ALU datapath and performs the inverse of the ALU's multiply path. It produces quotient and remainder for `DIV`/`DIVU`/`MOD` style operations. Operands are accepted with a start/done handshake, one quotient bit is resolved per clock, and results are held stable for the writeback stage until the next completion.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width in bits; must be ≥ 2.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a division; sampled only when the unit is accepting (IDLE or DONE).
- `dividend`  in  WIDTH  numerator; sampled on the accept edge.
- `divisor`  in  WIDTH  denominator; sampled on the accept edge.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `quotient`  out  WIDTH  registered quotient.
- `remainder`  out  WIDTH  registered remainder.
- `div_by_zero`  out  1  registered flag, valid with `done`.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- Accept: `start` is high while the state is IDLE or DONE.
  - The edge latches the operands, clears the partial remainder, and clears the bit counter to 0.
  - If divisor ≠ 0, the next state is CALC.
  - If divisor = 0, the next state is DONE directly.
- `start` during CALC is ignored and is not queued.
- CALC step, once per edge:
  - Shift {partial remainder, dividend register} left by one.
  - Trial-subtract the divisor from the partial remainder. This requires a WIDTH+1-bit subtractor so the borrow is never lost.
  - If the result is non-negative, keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Increment the counter.
- When the counter reaches WIDTH−1 on a CALC edge, that edge completes the last bit. On the same edge:
  - write `quotient`/`remainder`,
  - clear `div_by_zero`,
  - go to DONE.
- Divide by zero, on the accept edge: `quotient` is all ones, `remainder` equals `dividend`, `div_by_zero` is 1.
- DONE lasts exactly one cycle. It goes to IDLE, or to a new accept if `start` is high.
- Results and `div_by_zero` hold their values until the next completion. They are never cleared by going to IDLE.
- Unsigned arithmetic is the default (see Configuration).

## Timing
- Reset values, applied asynchronously on `rst_n` = 0:
  - state IDLE, counter 0,
  - `busy` 0, `done` 0,
  - `quotient` 0, `remainder` 0, `div_by_zero` 0.
- Reset mid-CALC aborts the operation immediately. No `done` is produced for the aborted request.
- `busy` = (state == CALC). `done` = (state == DONE). Both are decoded from registered state and are glitch-free.
- Normal latency: with the accept edge at edge 0, `done` is high in the cycle after edge WIDTH, i.e. WIDTH+1 edges from request to result (33 at default).
- Divide-by-zero latency: `done` is high in the cycle after the accept edge.
- Back-to-back: `start` held high through DONE gives a new accept on the DONE→next edge. Throughput is one result per WIDTH+1 cycles.
- `dividend`/`divisor` may change freely after the accept edge.

## Configuration
- `DIV32_SIGNED_EN` defined: operands are treated as two's complement.
  - The magnitudes are divided unsigned.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the dividend's sign (truncating division).
  - −2^(WIDTH−1) / −1 yields quotient 0x80000000 and remainder 0, with no extra flag.
  - Divide by zero yields quotient all ones and remainder = dividend, as in unsigned mode.
  - Sign fix-up is applied on the completing edge and adds no cycles.
- `DIV32_SIGNED_EN` undefined: purely unsigned. No sign logic is synthesized.

## Test plan
- Basic: 100 / 7 → after 33 cycles, `done` pulses once with quotient 14, remainder 2, `div_by_zero` 0; `busy` is high for exactly 32 cycles.
- Divide by zero: 0x1234 / 0 → `done` in the cycle after accept, quotient 0xFFFFFFFF, remainder 0x1234, `div_by_zero` 1, `busy` never high.
- Extremes (unsigned): 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0. 5 / 0xFFFFFFFF → quotient 0, remainder 5.
- Handshake: pulse `start` again mid-CALC with new operands → ignored, original result delivered. Then hold `start` through DONE → second result exactly 33 cycles after the first `done`.
- Reset abort: assert `rst_n` = 0 at CALC cycle 10 → all outputs 0 immediately, no `done`. A new 20 / 3 after release → quotient 6, remainder 2.
- With `DIV32_SIGNED_EN`:
  - −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1).
  - 7 / −2 → quotient −3, remainder 1.
  - 0x80000000 / −1 → quotient 0x80000000, remainder 0.
